// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with majority-voted sampling, break detection and an output FIFO
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uartrx,
  input  logic                 i_rxready,
  input  logic                 i_clr_err,
  output logic                 o_rxdatval,
  output logic [DATA_BITS-1:0] o_rxbyte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break,
  output logic                 o_busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int W    = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKWAIT} state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s2_q;
  logic [2:0]           hist_q;
  logic                 maj;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 psmp_q, psmp_d;
  logic [1:0]           sc_q, sc_d;
  logic                 ferr_q, ferr_d;
  logic                 fst_q, fst_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q;
  logic                 tick, perr, push, is_brk;
  logic [W-1:0]         word;
  logic [W-1:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]          wp_q, rp_q;
  logic                 full, empty, pop, wr;

  assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign tick = cnt_q == 16'(CLKS_PER_BIT - 1);
  assign perr = (PARITY != 0) && ((^data_q ^ psmp_q) != (PARITY == 1));
  assign word = {ferr_q | ~maj, perr, data_q};

  // two-flop synchroniser and voting history, idle-high at reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 3'b111;
    end else begin
      s1_q   <= i_uartrx;
      s2_q   <= s1_q;
      hist_q <= {hist_q[1:0], s2_q};
    end

  // receive state and frame registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      psmp_q  <= 1'b0;
      sc_q    <= '0;
      ferr_q  <= 1'b0;
      fst_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      psmp_q  <= psmp_d;
      sc_q    <= sc_d;
      ferr_q  <= ferr_d;
      fst_q   <= fst_d;
      brk_q   <= brk_d;
    end

  // next-state logic; data shifts in from the top so the first bit lands at the LSB
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    psmp_d  = psmp_q;
    sc_d    = sc_q;
    ferr_d  = ferr_q;
    fst_d   = fst_q;
    brk_d   = 1'b0;
    push    = 1'b0;
    is_brk  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        sc_d   = '0;
        ferr_d = 1'b0;
        if (!s2_q) state_d = START;
      end
      START:
        if (cnt_q == 16'(HALF)) begin
          cnt_d   = '0;
          state_d = maj ? IDLE : DATA;
        end
      DATA:
        if (tick) begin
          cnt_d  = '0;
          data_d = {maj, data_q[DATA_BITS-1:1]};
          idx_d  = idx_q + 4'd1;
          if (idx_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? PAR : STOP;
        end
      PAR:
        if (tick) begin
          cnt_d   = '0;
          psmp_d  = maj;
          state_d = STOP;
        end
      STOP:
        if (tick) begin
          cnt_d = '0;
          sc_d  = sc_q + 2'd1;
          if (!maj) ferr_d = 1'b1;
          if (sc_q == 2'd0) fst_d = maj;
          if (sc_q == 2'(STOP_BITS - 1)) begin
            push    = 1'b1;
            is_brk  = (data_q == '0) && (PARITY == 0 || !psmp_q) && !((sc_q == 2'd0) ? maj : fst_q);
            brk_d   = is_brk;
            state_d = is_brk ? BRKWAIT : IDLE;
          end
        end
      BRKWAIT: begin
        cnt_d = '0;
        if (s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = !empty && i_rxready;
  assign wr    = push && (!full || pop);

  // word FIFO and sticky overrun; a pop in the same cycle frees the slot for a push
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr) mem_q[wp_q[AW-1:0]] <= word;
      wp_q  <= wp_q + (AW+1)'(wr);
      rp_q  <= rp_q + (AW+1)'(pop);
      ovr_q <= (push && full && !pop) || (ovr_q && !i_clr_err);
    end

  assign o_rxdatval = !empty;
  assign {o_frame_err, o_parity_err, o_rxbyte} = mem_q[rp_q[AW-1:0]];
  assign o_overrun  = ovr_q;
  assign o_break    = brk_q;
  assign o_busy     = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg at 16 clocks per bit, 8E1
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic       val, perr, ferr, ovr, brk, busy;
  logic [7:0] byte_o;

  logic [9:0] exp_q [$];
  int checks = 0, errors = 0;
  int vcnt = 0, bcnt = 0, bzcnt = 0;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uartrx(rx), .i_rxready(rdy), .i_clr_err(clr),
    .o_rxdatval(val), .o_rxbyte(byte_o), .o_parity_err(perr), .o_frame_err(ferr),
    .o_overrun(ovr), .o_break(brk), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] model(input logic [7:0] d, input logic p, input logic s);
    return {~s, ^d ^ p, d};
  endfunction

  // frame bits: 0 start, 1..8 data, 9 parity, 10 stop; spike flips one mid-bit cycle, cut asserts reset mid-bit
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int spike, input int cut);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++)
      for (int c = 0; c < CPB; c++) begin
        if (i == cut && c == 8) begin
          rst_n = 1'b0;
          rx = 1'b1;
          return;
        end
        rx = (i == spike && c == 8) ? ~fr[i] : fr[i];
        cyc(1);
      end
    rx = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc(1);
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      if (val) vcnt++;
      if (brk) bcnt++;
      if (busy) bzcnt++;
      if (val && rdy) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word", 32'({ferr, perr, byte_o}), 32'(e));
        end
      end
    end
  end

  initial begin
    int v0, b0, z0;
    cyc(3);
    chk("rst_val", 32'(val), 0);
    chk("rst_byte", 32'(byte_o), 0);
    chk("rst_flags", 32'({perr, ferr, ovr, brk, busy}), 0);
    rst_n = 1'b1;
    cyc(5);

    rdy = 1'b1;
    v0 = vcnt;
    exp_q.push_back(model(8'hA5, 1'b0, 1'b1));
    send(8'hA5, 1'b0, 1'b1, -1, -1);
    cyc(32);
    drain(50);
    chk("clean_val_cycles", 32'(vcnt - v0), 1);

    exp_q.push_back(model(8'h3C, 1'b1, 1'b1));
    send(8'h3C, 1'b1, 1'b1, -1, -1);
    cyc(32);
    drain(50);
    exp_q.push_back(model(8'h3C, 1'b0, 1'b0));
    send(8'h3C, 1'b0, 1'b0, -1, -1);
    cyc(48);
    drain(50);

    z0 = bzcnt;
    v0 = vcnt;
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(40);
    chk("glitch_busy_le9", 32'((bzcnt - z0) <= 9), 1);
    chk("glitch_busy_seen", 32'((bzcnt - z0) > 0), 1);
    chk("glitch_no_push", 32'(vcnt - v0), 0);
    chk("glitch_idle", 32'(busy), 0);

    exp_q.push_back(model(8'h00, 1'b0, 1'b1));
    send(8'h00, 1'b0, 1'b1, 4, -1);
    cyc(32);
    drain(50);

    rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(model(8'(k), ^(8'(k)), 1'b1));
      send(8'(k), ^(8'(k)), 1'b1, -1, -1);
    end
    cyc(8);
    chk("overrun_set", 32'(ovr), 1);
    chk("full_val", 32'(val), 1);
    rdy = 1'b1;
    drain(50);
    cyc(2);
    chk("fifth_absent", 32'(val), 0);
    chk("overrun_sticky", 32'(ovr), 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("overrun_clr", 32'(ovr), 0);

    b0 = bcnt;
    exp_q.push_back(10'h200);
    rx = 1'b0;
    cyc(19 * CPB);
    chk("brk_busy_held", 32'(busy), 1);
    cyc(CPB);
    rx = 1'b1;
    cyc(8);
    chk("brk_busy_drop", 32'(busy), 0);
    chk("brk_pulses", 32'(bcnt - b0), 1);
    drain(50);
    cyc(16);
    exp_q.push_back(model(8'h5A, 1'b0, 1'b1));
    send(8'h5A, 1'b0, 1'b1, -1, -1);
    cyc(32);
    drain(50);

    rdy = 1'b0;
    send(8'h11, 1'b0, 1'b1, -1, -1);
    cyc(16);
    chk("pre_rst_val", 32'(val), 1);
    send(8'h77, 1'b0, 1'b1, -1, 5);
    cyc(1);
    chk("mid_rst_val", 32'(val), 0);
    chk("mid_rst_byte", 32'(byte_o), 0);
    chk("mid_rst_flags", 32'({perr, ferr, ovr, brk, busy}), 0);
    rst_n = 1'b1;
    rdy = 1'b1;
    cyc(8);
    chk("post_rst_idle", 32'({val, busy}), 0);
    exp_q.push_back(model(8'h96, 1'b0, 1'b1));
    send(8'h96, 1'b0, 1'b1, -1, -1);
    cyc(32);
    drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
